// File: rtl/aidc_lite_cc_sched_if.sv
// Requester/concatenator/result bundle for aidc_lite_cc_sched.
// timeout_o exists only when AIDC_LITE_CC_SCHED_TIMEOUT_EN is defined.
interface aidc_lite_cc_sched_if #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 66,
    parameter int ID_W      = 3
);
    logic [NUM_REQ-1:0]           req_valid_i;
    logic [NUM_REQ-1:0]           req_sop_i;
    logic [NUM_REQ-1:0]           req_eop_i;
    logic [NUM_REQ*DATA_SIZE-1:0] req_data_i;
    logic [NUM_REQ*7-1:0]         req_size_i;
    logic [NUM_REQ-1:0]           req_ready_o;
    logic                         cc_valid_o;
    logic                         cc_sop_o;
    logic                         cc_eop_o;
    logic [DATA_SIZE-1:0]         cc_data_o;
    logic [6:0]                   cc_size_o;
    logic                         cc_done_i;
    logic                         cc_fail_i;
    logic                         rslt_valid_o;
    logic [ID_W-1:0]              rslt_id_o;
    logic                         rslt_fail_o;
    logic                         busy_o;
`ifdef AIDC_LITE_CC_SCHED_TIMEOUT_EN
    logic                         timeout_o;
`endif

    modport slave (
        input  req_valid_i,
        input  req_sop_i,
        input  req_eop_i,
        input  req_data_i,
        input  req_size_i,
        input  cc_done_i,
        input  cc_fail_i,
        output req_ready_o,
        output cc_valid_o,
        output cc_sop_o,
        output cc_eop_o,
        output cc_data_o,
        output cc_size_o,
        output rslt_valid_o,
        output rslt_id_o,
        output rslt_fail_o,
        output busy_o
`ifdef AIDC_LITE_CC_SCHED_TIMEOUT_EN
       ,output timeout_o
`endif
    );

    modport master (
        output req_valid_i,
        output req_sop_i,
        output req_eop_i,
        output req_data_i,
        output req_size_i,
        output cc_done_i,
        output cc_fail_i,
        input  req_ready_o,
        input  cc_valid_o,
        input  cc_sop_o,
        input  cc_eop_o,
        input  cc_data_o,
        input  cc_size_o,
        input  rslt_valid_o,
        input  rslt_id_o,
        input  rslt_fail_o,
        input  busy_o
`ifdef AIDC_LITE_CC_SCHED_TIMEOUT_EN
       ,input  timeout_o
`endif
    );
endinterface

// File: rtl/aidc_lite_cc_sched.sv
// Round-robin block scheduler in front of a single code-concatenate datapath.
// Optional DRAIN watchdog: define AIDC_LITE_CC_SCHED_TIMEOUT_EN.
module aidc_lite_cc_sched #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_SIZE     = 66,
    parameter int ID_W          = 3,
    parameter int DRAIN_TIMEOUT = 15
) (
    input logic                clk,
    input logic                rst,
    aidc_lite_cc_sched_if.slave sched_io
);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN,
        REPORT
    } state_t;

    state_t          state_q;
    logic [ID_W-1:0] rr_q;
    logic [ID_W-1:0] grant_q;
    logic            first_q;
    logic            rslt_valid_q;
    logic [ID_W-1:0] rslt_id_q;
    logic            rslt_fail_q;

`ifdef AIDC_LITE_CC_SCHED_TIMEOUT_EN
    localparam int CNT_W = 8;
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;
`endif

    logic [NUM_REQ-1:0] elig;
    logic               pick_found;
    logic [ID_W-1:0]    pick_idx;
    logic [ID_W:0]      scan_idx;
    logic               g_valid;
    logic               g_sop;
    logic               g_eop;
    logic [DATA_SIZE-1:0] g_data;
    logic [6:0]         g_size;
    logic               streaming;
    logic [ID_W-1:0]    rr_next;

    assign g_valid   = sched_io.req_valid_i[grant_q];
    assign g_sop     = sched_io.req_sop_i[grant_q];
    assign g_eop     = sched_io.req_eop_i[grant_q];
    assign g_data    = sched_io.req_data_i[grant_q*DATA_SIZE +: DATA_SIZE];
    assign g_size    = sched_io.req_size_i[grant_q*7 +: 7];
    assign streaming = (state_q == STREAM);
    assign rr_next   = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

    // First sop-presenting lane at or after the rr pointer, wrapping.
    always_comb begin
        elig       = sched_io.req_valid_i & sched_io.req_sop_i;
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = {1'b0, rr_q} + (ID_W+1)'(i);
            if (scan_idx >= (ID_W+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
            end
            if (!pick_found && elig[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx[ID_W-1:0];
            end
        end
    end

    // Forward the granted lane; later sops inside a block are masked.
    always_comb begin
        sched_io.req_ready_o = '0;
        sched_io.cc_valid_o  = 1'b0;
        sched_io.cc_sop_o    = 1'b0;
        sched_io.cc_eop_o    = 1'b0;
        sched_io.cc_data_o   = '0;
        sched_io.cc_size_o   = '0;
        if (streaming) begin
            sched_io.req_ready_o[grant_q] = 1'b1;
            sched_io.cc_valid_o = g_valid;
            sched_io.cc_sop_o   = g_valid & g_sop & first_q;
            sched_io.cc_eop_o   = g_valid & g_eop;
            sched_io.cc_data_o  = g_data;
            sched_io.cc_size_o  = g_size;
        end
    end

    assign sched_io.rslt_valid_o = rslt_valid_q;
    assign sched_io.rslt_id_o    = rslt_id_q;
    assign sched_io.rslt_fail_o  = rslt_fail_q;
    assign sched_io.busy_o       = (state_q != IDLE);
`ifdef AIDC_LITE_CC_SCHED_TIMEOUT_EN
    assign sched_io.timeout_o    = timeout_q;
`endif

    // Block FSM: arbitrate, stream, wait for flush, pulse the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_q         <= '0;
            grant_q      <= '0;
            first_q      <= 1'b0;
            rslt_valid_q <= 1'b0;
            rslt_id_q    <= '0;
            rslt_fail_q  <= 1'b0;
`ifdef AIDC_LITE_CC_SCHED_TIMEOUT_EN
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            rslt_valid_q <= 1'b0;
            rslt_id_q    <= '0;
            rslt_fail_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        grant_q <= pick_idx;
                        first_q <= 1'b1;
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    if (g_valid) begin
                        first_q <= 1'b0;
                        if (g_eop) begin
                            state_q <= DRAIN;
`ifdef AIDC_LITE_CC_SCHED_TIMEOUT_EN
                            cnt_q   <= '0;
`endif
                        end
                    end
                end
                DRAIN: begin
                    if (sched_io.cc_done_i) begin
                        state_q      <= REPORT;
                        rslt_valid_q <= 1'b1;
                        rslt_id_q    <= grant_q;
                        rslt_fail_q  <= sched_io.cc_fail_i;
                    end
`ifdef AIDC_LITE_CC_SCHED_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(DRAIN_TIMEOUT - 1)) begin
                        state_q      <= REPORT;
                        rslt_valid_q <= 1'b1;
                        rslt_id_q    <= grant_q;
                        rslt_fail_q  <= 1'b1;
                        timeout_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                REPORT: begin
                    rr_q    <= rr_next;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aidc_lite_cc_sched.sv
// Bench for aidc_lite_cc_sched: block-level round-robin model plus
// directed scenarios with hand-computed literal expectations.
module tb_aidc_lite_cc_sched;

    localparam int NR = 4;
    localparam int DW = 66;
    localparam int IW = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    aidc_lite_cc_sched_if #(
        .NUM_REQ(NR), .DATA_SIZE(DW), .ID_W(IW)
    ) bus_if ();

    aidc_lite_cc_sched #(
        .NUM_REQ(NR), .DATA_SIZE(DW), .ID_W(IW), .DRAIN_TIMEOUT(15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sched_io(bus_if)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic [6:0]    s;
        bit            sop;
        bit            eop;
        bit            bub;
    } beat_t;

    typedef struct {
        int            cyc;
        logic [DW-1:0] d;
        logic [6:0]    s;
        bit            sop;
        bit            eop;
    } ccrec_t;

    typedef struct {
        int cyc;
        int id;
        bit fail;
    } rsrec_t;

    beat_t  lq[NR][$];
    bit     shown[NR];
    bit     fired[NR];
    int     fcnt[NR];
    ccrec_t cc_log[$];
    rsrec_t rs_log[$];
    bit     fq[$];
    int     done_delay = 1;
    int     dcnt = 0;
    int     cyc = 0;
    int     errors = 0;
    int     checks = 0;

    // block-level model: phase 0 free, 1 owned, 2 flushing, 3 reporting
    int m_ph = 0;
    int m_own = 0;
    int m_rr = 0;
    int m_dc = 0;
    bit m_first = 0;
    bit m_fail = 0;
    bit m_to = 0;

    function automatic logic [DW-1:0] mkd(int lane, int blk, int beat);
        return {2'(lane), 32'h5A5A_0000 | 32'(blk*16 + beat),
                32'hC0DE_0000 | 32'(lane)};
    endfunction

    function automatic logic [6:0] mks(int lane, int beat);
        return 7'(10 + beat*3 + lane);
    endfunction

    task automatic chk(string nm, logic [127:0] got, logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, got, exp);
        end
    endtask

    task automatic add_block(int lane, int blk, int nb, int bub_after, int nbub);
        for (int b = 0; b < nb; b++) begin
            lq[lane].push_back('{d: mkd(lane, blk, b), s: mks(lane, b),
                                 sop: (b == 0), eop: (b == nb-1), bub: 0});
            if (b == bub_after) begin
                for (int n = 0; n < nbub; n++) begin
                    lq[lane].push_back('{d: '0, s: '0, sop: 0, eop: 0, bub: 1});
                end
            end
        end
    endtask

    function automatic bit lanes_empty();
        for (int k = 0; k < NR; k++) begin
            if (lq[k].size() != 0) return 0;
        end
        return 1;
    endfunction

    task automatic drive();
        logic [NR-1:0]    v, sp, ep;
        logic [NR*DW-1:0] dd;
        logic [NR*7-1:0]  ss;
        v = '0; sp = '0; ep = '0; dd = '0; ss = '0;
        for (int k = 0; k < NR; k++) begin
            if (lq[k].size() > 0) begin
                if (lq[k][0].bub ? shown[k] : fired[k]) void'(lq[k].pop_front());
            end
            shown[k] = 0;
            if (lq[k].size() > 0) begin
                if (lq[k][0].bub) begin
                    shown[k] = 1;
                end else begin
                    v[k] = 1'b1;
                    sp[k] = lq[k][0].sop;
                    ep[k] = lq[k][0].eop;
                    dd[k*DW +: DW] = lq[k][0].d;
                    ss[k*7 +: 7] = lq[k][0].s;
                end
            end
        end
        bus_if.req_valid_i = v;
        bus_if.req_sop_i   = sp;
        bus_if.req_eop_i   = ep;
        bus_if.req_data_i  = dd;
        bus_if.req_size_i  = ss;
        bus_if.cc_done_i   = 1'b0;
        bus_if.cc_fail_i   = 1'b0;
        if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) begin
                bus_if.cc_done_i = 1'b1;
                if (fq.size() > 0) bus_if.cc_fail_i = fq.pop_front();
            end
        end
    endtask

    task automatic observe();
        logic [NR-1:0] vin, sin, ein, exp_rdy;
        bit            exp_v, exp_sop, exp_eop, exp_busy, exp_rv, exp_rf, bad;
        int            exp_id;
        logic [DW-1:0] exp_d;
        logic [6:0]    exp_s;
        vin = bus_if.req_valid_i;
        sin = bus_if.req_sop_i;
        ein = bus_if.req_eop_i;
        exp_rdy = '0; exp_v = 0; exp_sop = 0; exp_eop = 0;
        exp_rv = 0; exp_rf = 0; exp_id = 0; exp_d = '0; exp_s = '0;
        exp_busy = (m_ph != 0);
        if (m_ph == 1) begin
            exp_rdy[m_own] = 1'b1;
            exp_v   = vin[m_own];
            exp_sop = vin[m_own] & sin[m_own] & m_first;
            exp_eop = vin[m_own] & ein[m_own];
            exp_d   = bus_if.req_data_i[m_own*DW +: DW];
            exp_s   = bus_if.req_size_i[m_own*7 +: 7];
        end
        if (m_ph == 3) begin
            exp_rv = 1; exp_id = m_own; exp_rf = m_fail;
        end
        bad = (bus_if.req_ready_o !== exp_rdy) || (bus_if.cc_valid_o !== exp_v)
           || (bus_if.cc_sop_o !== exp_sop) || (bus_if.cc_eop_o !== exp_eop)
           || (bus_if.busy_o !== exp_busy) || (bus_if.rslt_valid_o !== exp_rv)
           || (bus_if.rslt_id_o !== 3'(exp_id)) || (bus_if.rslt_fail_o !== exp_rf)
           || (exp_v && ((bus_if.cc_data_o !== exp_d) || (bus_if.cc_size_o !== exp_s)));
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL cycle_check cyc=%0d got rdy=%b v=%b sop=%b eop=%b busy=%b rslt=%b/%0d/%b data=%h size=%0d required rdy=%b v=%b sop=%b eop=%b busy=%b rslt=%b/%0d/%b data=%h size=%0d",
                     cyc, bus_if.req_ready_o, bus_if.cc_valid_o, bus_if.cc_sop_o,
                     bus_if.cc_eop_o, bus_if.busy_o, bus_if.rslt_valid_o,
                     bus_if.rslt_id_o, bus_if.rslt_fail_o, bus_if.cc_data_o,
                     bus_if.cc_size_o, exp_rdy, exp_v, exp_sop, exp_eop, exp_busy,
                     exp_rv, exp_id, exp_rf, exp_d, exp_s);
        end
`ifdef AIDC_LITE_CC_SCHED_TIMEOUT_EN
        checks++;
        if (bus_if.timeout_o !== m_to) begin
            errors++;
            $display("FAIL timeout_flag cyc=%0d got %b required %b", cyc, bus_if.timeout_o, m_to);
        end
`endif
        if (bus_if.cc_valid_o === 1'b1)
            cc_log.push_back('{cyc: cyc, d: bus_if.cc_data_o, s: bus_if.cc_size_o,
                               sop: bus_if.cc_sop_o, eop: bus_if.cc_eop_o});
        if (bus_if.rslt_valid_o === 1'b1)
            rs_log.push_back('{cyc: cyc, id: int'(bus_if.rslt_id_o), fail: bus_if.rslt_fail_o});
        if (rst) dcnt = 0;
        else if (bus_if.cc_valid_o === 1'b1 && bus_if.cc_eop_o === 1'b1) dcnt = done_delay;
        for (int k = 0; k < NR; k++) begin
            fired[k] = !rst && vin[k] && (bus_if.req_ready_o[k] === 1'b1);
            if (fired[k]) fcnt[k]++;
        end
        if (rst) begin
            m_ph = 0; m_rr = 0; m_own = 0; m_first = 0; m_fail = 0; m_to = 0;
        end else begin
            case (m_ph)
                0: begin
                    for (int i = 0; i < NR; i++) begin
                        int j;
                        j = (m_rr + i) % NR;
                        if (m_ph == 0 && vin[j] && sin[j]) begin
                            m_own = j; m_first = 1; m_ph = 1;
                        end
                    end
                end
                1: begin
                    if (vin[m_own]) begin
                        m_first = 0;
                        if (ein[m_own]) begin
                            m_ph = 2; m_dc = 0;
                        end
                    end
                end
                2: begin
                    if (bus_if.cc_done_i) begin
                        m_fail = bus_if.cc_fail_i; m_ph = 3;
                    end else begin
                        m_dc++;
`ifdef AIDC_LITE_CC_SCHED_TIMEOUT_EN
                        if (m_dc == 15) begin
                            m_fail = 1; m_ph = 3; m_to = 1;
                        end
`endif
                    end
                end
                default: begin
                    m_rr = (m_own + 1) % NR; m_ph = 0;
                end
            endcase
        end
    endtask

    initial begin
        bus_if.req_valid_i = '0;
        bus_if.req_sop_i   = '0;
        bus_if.req_eop_i   = '0;
        bus_if.req_data_i  = '0;
        bus_if.req_size_i  = '0;
        bus_if.cc_done_i   = 1'b0;
        bus_if.cc_fail_i   = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            drive();
            @(negedge clk);
            observe();
        end
    end

    task automatic wait_idle(string nm, int maxc);
        int stable;
        stable = 0;
        for (int i = 0; i < maxc; i++) begin
            @(posedge clk);
            #3;
            if (lanes_empty() && m_ph == 0 && dcnt == 0) stable++;
            else stable = 0;
            if (stable >= 2) return;
        end
        checks++;
        errors++;
        $display("FAIL %s: no idle within %0d cycles", nm, maxc);
    endtask

    task automatic clear_logs();
        cc_log.delete();
        rs_log.delete();
    endtask

    initial begin
        int order[5];
        int n_bad;
        int base;
        order = '{0, 1, 2, 3, 0};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        chk("reset_ready", bus_if.req_ready_o, 0);
        chk("reset_cc_valid", bus_if.cc_valid_o, 0);
        chk("reset_busy", bus_if.busy_o, 0);
        chk("reset_rslt_valid", bus_if.rslt_valid_o, 0);
        rst = 1'b0;

        // all four lanes at once, 3 beats each, lane 0 twice
        clear_logs();
        done_delay = 2;
        add_block(0, 0, 3, -1, 0);
        add_block(1, 0, 3, -1, 0);
        add_block(2, 0, 3, -1, 0);
        add_block(3, 0, 3, -1, 0);
        add_block(0, 1, 3, -1, 0);
        wait_idle("rr_idle", 300);
        chk("rr_count", rs_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < rs_log.size()) chk($sformatf("rr_grant%0d", i), rs_log[i].id, order[i]);
        end
        chk("rr_beats", cc_log.size(), 15);
        n_bad = 0;
        for (int i = 0; i < 5; i++) begin
            for (int b = 0; b < 3; b++) begin
                if (i*3 + b < cc_log.size()) begin
                    if (cc_log[i*3+b].d !== mkd(order[i], (i == 4) ? 1 : 0, b)) n_bad++;
                    if (cc_log[i*3+b].s !== mks(order[i], b)) n_bad++;
                end
            end
        end
        chk("rr_beat_order", n_bad, 0);

        // single-beat block on lane 2
        clear_logs();
        done_delay = 1;
        add_block(2, 0, 1, -1, 0);
        lq[2][0].s = 7'd6;
        wait_idle("single_idle", 100);
        chk("single_beats", cc_log.size(), 1);
        chk("single_rslts", rs_log.size(), 1);
        if (cc_log.size() == 1 && rs_log.size() == 1) begin
            chk("single_sop_eop", {cc_log[0].sop, cc_log[0].eop}, 2'b11);
            chk("single_size", cc_log[0].s, 6);
            chk("single_latency", rs_log[0].cyc - cc_log[0].cyc, 2);
            chk("single_id", rs_log[0].id, 2);
            chk("single_fail", rs_log[0].fail, 0);
        end

        // lane 3 bubbles two cycles mid-block
        clear_logs();
        add_block(3, 0, 4, 1, 2);
        wait_idle("bubble_idle", 100);
        chk("bubble_beats", cc_log.size(), 4);
        chk("bubble_rslts", rs_log.size(), 1);
        if (cc_log.size() == 4) chk("bubble_gap", cc_log[2].cyc - cc_log[1].cyc, 3);
        if (rs_log.size() == 1) chk("bubble_id", rs_log[0].id, 3);

        // concatenator fail then clean block, both lane 1
        clear_logs();
        fq.push_back(1'b1);
        fq.push_back(1'b0);
        add_block(1, 0, 2, -1, 0);
        add_block(1, 1, 2, -1, 0);
        wait_idle("fail_idle", 100);
        chk("fail_rslts", rs_log.size(), 2);
        if (rs_log.size() == 2) begin
            chk("fail_id0", rs_log[0].id, 1);
            chk("fail_flag0", rs_log[0].fail, 1);
            chk("fail_id1", rs_log[1].id, 1);
            chk("fail_flag1", rs_log[1].fail, 0);
        end

        // reset in the middle of a 4-beat block
        clear_logs();
        base = fcnt[0];
        add_block(0, 0, 4, -1, 0);
        for (int i = 0; i < 50 && fcnt[0] < base + 2; i++) begin
            @(posedge clk);
            #3;
        end
        chk("rst_two_beats", fcnt[0] - base >= 2, 1);
        rst = 1'b1;
        for (int k = 0; k < NR; k++) lq[k].delete();
        @(posedge clk);
        #3;
        chk("rst_ready", bus_if.req_ready_o, 0);
        chk("rst_cc", {bus_if.cc_valid_o, bus_if.cc_sop_o, bus_if.cc_eop_o}, 0);
        chk("rst_cc_data", {bus_if.cc_data_o, bus_if.cc_size_o}, 0);
        chk("rst_rslt", {bus_if.rslt_valid_o, bus_if.rslt_id_o, bus_if.rslt_fail_o}, 0);
        chk("rst_busy", bus_if.busy_o, 0);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        chk("rst_no_rslt", rs_log.size(), 0);
        add_block(1, 0, 1, -1, 0);
        add_block(3, 0, 1, -1, 0);
        wait_idle("rst_idle", 100);
        chk("rst_rslts", rs_log.size(), 2);
        if (rs_log.size() == 2) begin
            chk("rst_rr_first", rs_log[0].id, 1);
            chk("rst_rr_second", rs_log[1].id, 3);
        end

`ifdef AIDC_LITE_CC_SCHED_TIMEOUT_EN
        // done never arrives: watchdog forces a failed result
        clear_logs();
        done_delay = 0;
        add_block(0, 0, 1, -1, 0);
        wait_idle("to_idle", 100);
        chk("to_rslts", rs_log.size(), 1);
        if (rs_log.size() == 1 && cc_log.size() == 1) begin
            chk("to_latency", rs_log[0].cyc - cc_log[0].cyc, 16);
            chk("to_fail", rs_log[0].fail, 1);
        end
        chk("to_flag", bus_if.timeout_o, 1);
        repeat (3) @(posedge clk);
        #3;
        chk("to_sticky", bus_if.timeout_o, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: bench did not finish, time %0t", $time);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
